// File: rtl/ram_stream_reader_if.sv
// Bundles the readout control, RAM read port and output stream of ram_stream_reader.
// The master modport is the reader itself; the slave modport is its environment.
interface ram_stream_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  busy;
    logic                  done;
    logic                  ram_en;
    logic [ADDR_WIDTH-1:0] ram_r_addr;
    logic [DATA_WIDTH-1:0] ram_do;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  start, base_addr, length, ram_do, m_ready,
        output busy, done, ram_en, ram_r_addr, m_data, m_valid
    );

    modport slave (
        output start, base_addr, length, ram_do, m_ready,
        input  busy, done, ram_en, ram_r_addr, m_data, m_valid
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Reads a wrapping window of the sample RAM and streams it out on valid/ready,
// hiding the RAM's one-cycle read latency behind a 2-entry output FIFO.
module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_stream_reader_if.master  bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH:0]   out_cnt_q, out_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            count_q, count_d;

    logic                  pop, push, issue;
    logic [1:0]            credit_used;

    assign pop  = (count_q != 2'd0) && bus.m_ready;
    assign push = inflight_q;

    // A word leaving the FIFO this cycle already frees its slot, so the
    // stream sustains one word per cycle without ever exceeding two entries.
    assign credit_used = count_q - {1'b0, pop} + {1'b0, inflight_q};
    assign issue       = (state_q == READ) && (issue_cnt_q != '0) && (credit_used < 2'd2);
    assign count_d     = count_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (pop) begin
            out_cnt_d = out_cnt_q - CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rd_addr_d   = bus.base_addr;
                    issue_cnt_d = bus.length;
                    out_cnt_d   = bus.length;
                    if (bus.length == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = READ;
                        busy_d  = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
                    issue_cnt_d = issue_cnt_q - CNT_ONE;
                    if (issue_cnt_q == CNT_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave on the edge of the final transfer so done follows it directly.
                if (out_cnt_d == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            inflight_q  <= issue;
            count_q     <= count_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= bus.ram_do;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.ram_en     = issue;
    assign bus.ram_r_addr = rd_addr_q;
    assign bus.m_valid    = (count_q != 2'd0);
    assign bus.m_data     = (count_q != 2'd0) ? buf_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: a RAM model feeds the reader, stimulus
// queues expected words/addresses, and a negedge monitor checks them.
module tb_ram_stream_reader;
    localparam int DW = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [DW-1:0] mem [16];
    logic [DW-1:0] ram_do_q = '0;
    always @(posedge clk) if (bus.ram_en) ram_do_q <= mem[bus.ram_r_addr];
    assign bus.ram_do = ram_do_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] exp_addr_q [$];

    logic mon_en = 1'b0;
    int   en_cnt, valid_cnt, first_en, first_valid, done_cnt, done_cyc, last_xfer;
    int   issued, xfers;
    bit   seen_done, held;
    logic [DW-1:0] held_data;

    bit       bp_mode = 1'b0;
    logic     ready_level = 1'b1;
    int       bp_idx = 0;
    bit [6:0] bp_pat = 7'b1101001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic chk_le(input string name, input int act, input int lim);
        total++;
        if (act <= lim) passed++;
        else $display("FAIL %s: got %0d, expected at most %0d (t=%0t)", name, act, lim, $time);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        total++;
        $display("FAIL %s: got %0h, expected nothing (t=%0t)", name, act, $time);
    endtask

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.m_ready = bp_mode ? bp_pat[bp_idx % 7] : ready_level;
            bp_idx++;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (held) chk("hold_stable", {23'd0, bus.m_valid, bus.m_data}, {23'd0, 1'b1, held_data});
            held      = bus.m_valid && !bus.m_ready;
            held_data = bus.m_data;
            if (bus.ram_en) begin
                en_cnt++;
                if (first_en < 0) first_en = cyc;
                if (exp_addr_q.size() == 0) fail_now("addr_unexpected", 32'(bus.ram_r_addr));
                else chk("ram_r_addr", 32'(bus.ram_r_addr), 32'(exp_addr_q.pop_front()));
                chk_le("credit", issued + 1 - xfers - ((bus.m_valid && bus.m_ready) ? 1 : 0), 2);
            end
            if (bus.m_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) fail_now("data_unexpected", 32'(bus.m_data));
                else chk("m_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
                last_xfer = cyc;
                xfers++;
            end
            if (bus.ram_en) issued++;
            if (bus.done) begin
                done_cnt++;
                done_cyc  = cyc;
                seen_done = 1'b1;
            end
        end
    end

    task automatic run(input logic [AW-1:0] base, input logic [AW:0] n, input bit bp,
                       input int dup_off, input bit timing);
        int k;
        int c;
        logic [AW-1:0] a;
        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < int'(n); i++) begin
            a = base + AW'(i);
            exp_addr_q.push_back(a);
            exp_q.push_back(8'h10 + {4'h0, a});
        end
        en_cnt = 0; valid_cnt = 0; first_en = -1; first_valid = -1;
        done_cnt = 0; done_cyc = -1; last_xfer = -1; issued = 0; xfers = 0;
        seen_done = 1'b0; held = 1'b0;
        bp_mode = bp; bp_idx = 0; mon_en = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = base; bus.length = n;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = cyc;
        if (n != 0) chk("busy_high", 32'(bus.busy), 32'd1);
        c = 0;
        while (!seen_done && c < 300) begin
            if (c == dup_off) begin
                bus.start = 1'b1; bus.base_addr = 4'd9; bus.length = 5'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        bus.start = 1'b0;
        if (!seen_done) fail_now("done_timeout", 32'(c));
        repeat (3) @(posedge clk);
        #1;
        bp_mode = 1'b0;
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("queue_empty", 32'(exp_q.size() + exp_addr_q.size()), 32'd0);
        chk("busy_after", 32'(bus.busy), 32'd0);
        if (timing) begin
            if (n == 0) begin
                chk("done_cyc_len0", 32'(done_cyc), 32'(k));
                chk("no_ram_en", 32'(en_cnt), 32'd0);
                chk("no_valid", 32'(valid_cnt), 32'd0);
            end else begin
                chk("first_en_cyc", 32'(first_en), 32'(k));
                chk("first_valid_cyc", 32'(first_valid), 32'(k + 2));
                chk("done_cyc", 32'(done_cyc), 32'(k + int'(n) + 2));
            end
        end else begin
            chk("done_after_last", 32'(done_cyc), 32'(last_xfer + 1));
        end
        mon_en = 1'b0;
    endtask

    initial begin
        int dn;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.length = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
        chk("rst_ram_r_addr", 32'(bus.ram_r_addr), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_data", 32'(bus.m_data), 32'd0);
        rst = 1'b0;

        run(4'd3, 5'd4, 1'b0, -1, 1'b1);
        run(4'd14, 5'd4, 1'b0, -1, 1'b1);
        run(4'd0, 5'd6, 1'b1, -1, 1'b0);
        run(4'd0, 5'd0, 1'b0, -1, 1'b1);
        run(4'd5, 5'd16, 1'b0, -1, 1'b1);
        run(4'd3, 5'd4, 1'b0, 2, 1'b1);
        run(4'd2, 5'd3, 1'b0, 5, 1'b1);

        // Abort with two words parked in the FIFO.
        ready_level = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = 4'd0; bus.length = 5'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_full_valid", 32'(bus.m_valid), 32'd1);
        chk("bp_full_no_issue", 32'(bus.ram_en), 32'd0);
        chk("bp_head_data", 32'(bus.m_data), 32'h10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_m_valid", 32'(bus.m_valid), 32'd0);
        chk("abort_ram_en", 32'(bus.ram_en), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done) dn++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        ready_level = 1'b1;
        run(4'd7, 5'd3, 1'b0, -1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
